// File: rtl/mixer_pipe.sv
// Pipelined interpolator x LO mixer with amplitude scaling and sticky saturation.
// Define MIXER_ROUND_EN for round-half-up shifts; the default build truncates.
module mixer_pipe #(
  parameter int DW = 20,
  parameter int AW = 25,
  parameter int LO_SHIFT = 15,
  parameter int AMP_FRAC = 23,
  parameter logic [AW-1:0] AMP_DEFAULT = AW'(25'h028619A)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic signed [DW-1:0] interp_i,
  input  logic signed [DW-1:0] lo_i,
  input  logic                 amp_wr,
  input  logic signed [AW-1:0] amp_data,
  output logic signed [AW-1:0] amp_o,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic signed [DW-1:0] mix_o,
  output logic                 sat_o,
  input  logic                 sat_clr
);

  localparam int PW = 2 * DW;
  localparam int MW = DW + AW;

  localparam logic signed [PW:0] HI1 =
    {{(PW-DW+2){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [PW:0] LO1 =
    {{(PW-DW+2){1'b1}}, {(DW-1){1'b0}}};
  localparam logic signed [MW:0] HI3 =
    {{(MW-DW+2){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [MW:0] LO3 =
    {{(MW-DW+2){1'b1}}, {(DW-1){1'b0}}};
  localparam logic signed [DW-1:0] DMAX = {1'b0, {(DW-1){1'b1}}};
  localparam logic signed [DW-1:0] DMIN = {1'b1, {(DW-1){1'b0}}};

  // Extra top bit keeps the rounding add from wrapping.
`ifdef MIXER_ROUND_EN
  localparam logic signed [PW:0] RND1 =
    {{PW{1'b0}}, 1'b1} << (LO_SHIFT - 1);
  localparam logic signed [MW:0] RND3 =
    {{MW{1'b0}}, 1'b1} << (AMP_FRAC - 1);
`else
  localparam logic signed [PW:0] RND1 = '0;
  localparam logic signed [MW:0] RND3 = '0;
`endif

  logic                 en;
  logic                 v1;
  logic                 v2;
  logic signed [PW-1:0] p1;
  logic signed [MW-1:0] m2;
  logic signed [PW-1:0] p1_d;
  logic signed [MW-1:0] m2_d;
  logic signed [PW:0]   x1;
  logic signed [PW:0]   s1;
  logic signed [DW-1:0] i2;
  logic                 c1;
  logic signed [MW:0]   x3;
  logic signed [MW:0]   s3;
  logic signed [DW-1:0] mix_d;
  logic                 c3;

  assign en = !out_valid || out_ready;
  assign in_ready = en;

  always_comb begin
    p1_d = $signed({{DW{interp_i[DW-1]}}, interp_i})
         * $signed({{DW{lo_i[DW-1]}}, lo_i});

    x1 = $signed({p1[PW-1], p1}) + RND1;
    s1 = x1 >>> LO_SHIFT;
    c1 = 1'b0;
    i2 = s1[DW-1:0];
    if (s1 > HI1) begin
      i2 = DMAX;
      c1 = 1'b1;
    end else if (s1 < LO1) begin
      i2 = DMIN;
      c1 = 1'b1;
    end

    m2_d = $signed({{AW{i2[DW-1]}}, i2})
         * $signed({{DW{amp_o[AW-1]}}, amp_o});

    x3 = $signed({m2[MW-1], m2}) + RND3;
    s3 = x3 >>> AMP_FRAC;
    c3 = 1'b0;
    mix_d = s3[DW-1:0];
    if (s3 > HI3) begin
      mix_d = DMAX;
      c3 = 1'b1;
    end else if (s3 < LO3) begin
      mix_d = DMIN;
      c3 = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v1        <= 1'b0;
      v2        <= 1'b0;
      out_valid <= 1'b0;
      p1        <= '0;
      m2        <= '0;
      mix_o     <= '0;
      sat_o     <= 1'b0;
      amp_o     <= AMP_DEFAULT;
    end else begin
      if (amp_wr)
        amp_o <= amp_data;
      if (en) begin
        v1        <= in_valid;
        p1        <= p1_d;
        v2        <= v1;
        m2        <= m2_d;
        out_valid <= v2;
        mix_o     <= mix_d;
      end
      // A clip on the same edge as sat_clr wins.
      sat_o <= (sat_o && !sat_clr)
            || (en && ((v1 && c1) || (v2 && c3)));
    end
  end

endmodule

// File: tb/tb_mixer_pipe.sv
// Directed self-checking bench for mixer_pipe.
// Expected values are hand-derived from the default parameters.
module tb_mixer_pipe;

  logic               clk = 1'b0;
  logic               rst;
  logic               in_valid;
  logic               in_ready;
  logic signed [19:0] interp_i;
  logic signed [19:0] lo_i;
  logic               amp_wr;
  logic signed [24:0] amp_data;
  logic signed [24:0] amp_o;
  logic               out_valid;
  logic               out_ready;
  logic signed [19:0] mix_o;
  logic               sat_o;
  logic               sat_clr;

  int chk_cnt = 0;
  int pass_cnt = 0;

  mixer_pipe dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .interp_i  (interp_i),
    .lo_i      (lo_i),
    .amp_wr    (amp_wr),
    .amp_data  (amp_data),
    .amp_o     (amp_o),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .mix_o     (mix_o),
    .sat_o     (sat_o),
    .sat_clr   (sat_clr)
  );

  always #5 clk = ~clk;

`ifdef MIXER_ROUND_EN
  localparam logic [19:0] BASIC_EXP = 20'h1430D;
`else
  localparam logic [19:0] BASIC_EXP = 20'h1430C;
`endif

  task automatic run_one(input logic [19:0] a, input logic [19:0] b,
                         output logic [19:0] got, output int lat);
    @(negedge clk);
    in_valid = 1'b1;
    interp_i = a;
    lo_i = b;
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 8) begin
      @(negedge clk);
      lat++;
    end
    got = mix_o;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk_cnt++;
    if (out_valid !== 1'b0) $display("FAIL reset_valid got %b want 0", out_valid);
    else pass_cnt++;
    chk_cnt++;
    if (mix_o !== 20'h0) $display("FAIL reset_mix got %h want 00000", mix_o);
    else pass_cnt++;
    chk_cnt++;
    if (sat_o !== 1'b0) $display("FAIL reset_sat got %b want 0", sat_o);
    else pass_cnt++;
    chk_cnt++;
    if (amp_o !== 25'h028619A) $display("FAIL reset_amp got %h want 028619a", amp_o);
    else pass_cnt++;
    rst = 1'b0;
    @(negedge clk);
    chk_cnt++;
    if (in_ready !== 1'b1) $display("FAIL reset_ready got %b want 1", in_ready);
    else pass_cnt++;
  endtask

  task automatic test_basic;
    logic [19:0] got;
    int lat;
    run_one(20'h40000, 20'h08000, got, lat);
    chk_cnt++;
    if (lat !== 3) $display("FAIL basic_latency got %0d want 3", lat);
    else pass_cnt++;
    chk_cnt++;
    if (got !== BASIC_EXP) $display("FAIL basic_mix got %h want %h", got, BASIC_EXP);
    else pass_cnt++;
    chk_cnt++;
    if (sat_o !== 1'b0) $display("FAIL basic_sat got %b want 0", sat_o);
    else pass_cnt++;
  endtask

  task automatic test_negative;
    logic [19:0] got;
    int lat;
    run_one(20'hC0000, 20'h08000, got, lat);
    chk_cnt++;
    if (got !== 20'hEBCF3) $display("FAIL neg_mix got %h want ebcf3", got);
    else pass_cnt++;
    chk_cnt++;
    if (sat_o !== 1'b0) $display("FAIL neg_sat got %b want 0", sat_o);
    else pass_cnt++;
  endtask

  task automatic test_saturation;
    logic [19:0] got;
    int lat;
    run_one(20'h7FFFF, 20'h7FFFF, got, lat);
    chk_cnt++;
    if (got !== 20'h28619) $display("FAIL sat_mix got %h want 28619", got);
    else pass_cnt++;
    chk_cnt++;
    if (sat_o !== 1'b1) $display("FAIL sat_set got %b want 1", sat_o);
    else pass_cnt++;
    sat_clr = 1'b1;
    @(negedge clk);
    sat_clr = 1'b0;
    chk_cnt++;
    if (sat_o !== 1'b0) $display("FAIL sat_clear got %b want 0", sat_o);
    else pass_cnt++;
  endtask

  task automatic test_amp_write;
    logic [19:0] got;
    int lat;
    @(negedge clk);
    amp_wr = 1'b1;
    amp_data = 25'h0800000;
    @(negedge clk);
    amp_wr = 1'b0;
    chk_cnt++;
    if (amp_o !== 25'h0800000) $display("FAIL amp_reg got %h want 0800000", amp_o);
    else pass_cnt++;
    run_one(20'h40000, 20'h08000, got, lat);
    chk_cnt++;
    if (got !== 20'h40000) $display("FAIL amp_mix got %h want 40000", got);
    else pass_cnt++;
  endtask

  // Unity amplitude and LO = 2^15 make each output equal its input.
  task automatic test_back_to_back;
    logic [19:0] vec [8];
    logic [19:0] got [$];
    logic [19:0] held;
    bit was_st;
    int k;
    vec = '{20'h01234, 20'h7FFFF, 20'h80000, 20'hFEDCB,
            20'h00001, 20'hFFFFF, 20'h3C3C3, 20'hC3C3C};
    k = 0;
    was_st = 1'b0;
    held = '0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      out_ready = !(c >= 6 && c < 11);
      in_valid = (k < 8);
      interp_i = (k < 8) ? vec[k] : 20'h0;
      lo_i = 20'h08000;
      #1;
      if (out_valid && !out_ready) begin
        chk_cnt++;
        if (in_ready !== 1'b0) $display("FAIL stall_ready cyc %0d got %b want 0", c, in_ready);
        else pass_cnt++;
        if (was_st) begin
          chk_cnt++;
          if (mix_o !== held) $display("FAIL stall_hold cyc %0d got %h want %h", c, mix_o, held);
          else pass_cnt++;
        end
        held = mix_o;
        was_st = 1'b1;
      end else begin
        was_st = 1'b0;
      end
      if (out_valid && out_ready) got.push_back(mix_o);
      if (in_valid && in_ready) k++;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    chk_cnt++;
    if (got.size() !== 8) $display("FAIL stream_count got %0d want 8", got.size());
    else pass_cnt++;
    for (int i = 0; i < 8; i++) begin
      chk_cnt++;
      if (i >= got.size()) $display("FAIL stream_data[%0d] got none want %h", i, vec[i]);
      else if (got[i] !== vec[i]) $display("FAIL stream_data[%0d] got %h want %h", i, got[i], vec[i]);
      else pass_cnt++;
    end
  endtask

  task automatic test_reset_midstream;
    int seen;
    @(negedge clk);
    in_valid = 1'b1;
    interp_i = 20'h7FFFF;
    lo_i = 20'h7FFFF;
    @(negedge clk);
    interp_i = 20'h01000;
    lo_i = 20'h08000;
    @(negedge clk);
    interp_i = 20'h02000;
    @(negedge clk);
    in_valid = 1'b0;
    chk_cnt++;
    if (sat_o !== 1'b1) $display("FAIL mid_pre_sat got %b want 1", sat_o);
    else pass_cnt++;
    rst = 1'b1;
    @(negedge clk);
    chk_cnt++;
    if (out_valid !== 1'b0) $display("FAIL mid_valid got %b want 0", out_valid);
    else pass_cnt++;
    chk_cnt++;
    if (mix_o !== 20'h0) $display("FAIL mid_mix got %h want 00000", mix_o);
    else pass_cnt++;
    chk_cnt++;
    if (amp_o !== 25'h028619A) $display("FAIL mid_amp got %h want 028619a", amp_o);
    else pass_cnt++;
    chk_cnt++;
    if (sat_o !== 1'b0) $display("FAIL mid_sat got %b want 0", sat_o);
    else pass_cnt++;
    rst = 1'b0;
    seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    chk_cnt++;
    if (seen !== 0) $display("FAIL mid_stale got %0d want 0", seen);
    else pass_cnt++;
  endtask

  // Most negative squared must clip positive; sat_clr held across the clip.
  task automatic test_extreme;
    @(negedge clk);
    in_valid = 1'b1;
    interp_i = 20'h80000;
    lo_i = 20'h80000;
    sat_clr = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    chk_cnt++;
    if (sat_o !== 1'b1) $display("FAIL clr_collide got %b want 1", sat_o);
    else pass_cnt++;
    sat_clr = 1'b0;
    @(negedge clk);
    chk_cnt++;
    if (out_valid !== 1'b1) $display("FAIL ext_valid got %b want 1", out_valid);
    else pass_cnt++;
    chk_cnt++;
    if (mix_o !== 20'h28619) $display("FAIL ext_mix got %h want 28619", mix_o);
    else pass_cnt++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    interp_i = '0;
    lo_i = '0;
    amp_wr = 1'b0;
    amp_data = '0;
    out_ready = 1'b1;
    sat_clr = 1'b0;
    test_reset();
    test_basic();
    test_negative();
    test_saturation();
    test_amp_write();
    test_back_to_back();
    test_reset_midstream();
    test_extreme();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
